spi_regfile_peripheral: RTL and testbench
=========================================

Name: spi_regfile_peripheral

Overview:
- Parametrised SPI mode-0 slave with a register file of NUM_REGS × DATA_W bits, and read-back over CIPO.
- It is the successor to the fixed 5×8-bit write-only SPI config block.
- It sits between the chip pins (sclk/copi/ncs after the pad ring) and the PWM/output-enable fabric, which consumes the flat register bus.
- New over the previous generation: R/W bit, read data on CIPO, address range check, over/under-length detection, and commit/error strobes.

Parameters:
NUM_REGS, 8, number of registers (1..2**ADDR_W)
DATA_W, 8, register width in bits (1..32)
ADDR_W, 7, address field width in bits
SYNC_STAGES, 2, synchroniser depth for sclk/copi/ncs (>=2)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
sclk  in  1  SPI clock (async to clk), idle low
copi  in  1  SPI controller-out data
ncs  in  1  SPI chip select, active-low
cipo  out  1  SPI peripheral-out data
cipo_oe  out  1  CIPO output enable; high only while a read data phase is active
regs_out  out  NUM_REGS*DATA_W  flat register bus; reg i = regs_out[i*DATA_W +: DATA_W]
wr_strobe  out  1  one-clk pulse when a write commits
wr_addr  out  ADDR_W  address of the last committed write
frame_err  out  1  one-clk pulse when a frame is rejected

Behaviour:
- Reset (rst=1, async): all registers 0, regs_out=0, cipo=0, cipo_oe=0, wr_strobe=0, wr_addr=0, frame_err=0, state IDLE, sync flops load idle levels (sclk=0, ncs=1).
- Synchronisation:
  - All three inputs pass through SYNC_STAGES flops.
  - Edges are detected from the last two stages.
  - Input-to-edge latency is SYNC_STAGES+1 clk.
- Frame format:
  - FRAME_LEN = 1+ADDR_W+DATA_W bits, each field MSB-first.
  - Bit 0 is R/W (1=write, 0=read), then the address, then the data.
  - COPI is sampled on sclk rising edges only while synchronised ncs=0.
- FSM states: IDLE, CMD, ADDR, DATA, DONE.
  - IDLE->CMD on ncs falling edge; bit counter cleared.
  - CMD->ADDR after 1 bit.
  - ADDR->DATA after ADDR_W bits.
  - DATA->DONE after DATA_W bits.
  - Any state->IDLE on ncs rising edge.
- Bit counter:
  - Width clog2(FRAME_LEN+2).
  - Saturates at FRAME_LEN+1, so extra sclk edges only mark the frame over-length.
- Read path:
  - On the clk after the last address bit, if addr<NUM_REGS, the addressed register is snapshotted into the tx shift register; otherwise the shift register loads 0.
  - cipo_oe rises on that same clk.
  - cipo presents the data MSB immediately, then shifts on each synchronised sclk falling edge.
  - cipo_oe drops on ncs rising edge or reset.
  - Writes arriving later do not alter the snapshot.
- Commit: evaluated on the clk after ncs rising edge detection.
  - Write, count==FRAME_LEN, addr<NUM_REGS: register[addr]<=data, wr_strobe=1, wr_addr<=addr.
  - Read, count==FRAME_LEN, addr<NUM_REGS: no register change, no strobe.
  - Any other case (short, long, or out-of-range address): frame_err=1 and no register change.
  - ncs rising with count==0 (empty select) is silent: no error.
- Simultaneous events:
  - An sclk edge in the same clk as ncs rising is ignored.
  - An ncs falling edge in the same clk as a pending commit: the commit completes first and the new frame starts with count 0.
- Reset mid-frame aborts the frame with no commit and no strobe.
- Timing requirement: the sclk high and low phases must each be >= SYNC_STAGES+2 clk periods. Faster sclk is unsupported.
- DATA_W > ADDR_W-related truncation does not exist: fields are independent widths.

Decomposition:
- Package spi_regfile_pkg holds:
  - the FSM state enum;
  - the FRAME_LEN function;
  - the counter-width function (clog2);
  - RW_WRITE=1'b1.
- One sub-module: spi_sync_edge (SYNC_STAGES-deep synchroniser with rise/fall pulse outputs), instantiated for sclk and ncs. copi uses sync only.

Test Plan:
- Write reg 2 = 0xA5 (frame 1,0000010,10100101), then read reg 2 -> regs_out[23:16]=0xA5, wr_strobe one pulse with wr_addr=2; read frame returns CIPO bits 10100101 with cipo_oe high only during the data phase.
- Write addr 9 (>=NUM_REGS) data 0xFF -> frame_err pulse, regs_out unchanged, no wr_strobe; read addr 9 -> CIPO all 0, frame_err pulse.
- 15-bit frame and 17-bit frame, both write reg 0 = 0x3C -> frame_err each, reg 0 stays 0; ncs toggle with 0 sclk edges -> no frame_err.
- Fill all 8 regs with 0x11×(i+1) back-to-back (ncs high for SYNC_STAGES+3 clk between frames) -> regs_out = 0x8877665544332211.
- Assert rst for 1 clk after 10 bits of a write -> all outputs 0; the next full write to reg 1 = 0x5A commits normally.
- Read reg 3 (=0x0F) while sclk runs at the minimum legal phase length -> CIPO stream 00001111 sampled correctly on sclk rising edges.

Source files
------------

// File: rtl/spi_regfile_pkg.sv
// Shared types and sizing helpers for the SPI register-file peripheral.
`timescale 1ns/1ps
package spi_regfile_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    DONE
  } state_e;

  localparam logic RW_WRITE = 1'b1;

  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Counter must hold FRAME_LEN+1 so an over-length frame stays distinguishable.
  function automatic int cnt_width(input int flen);
    return clog2(flen + 2);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with one-clk rise/fall pulses
// derived from the synchronised level and its one-clk-delayed copy.
`timescale 1ns/1ps
module spi_sync_edge #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{IDLE_LVL}};
      last_q <= IDLE_LVL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      last_q <= sync_q[STAGES-1];
    end
  end

  assign lvl  = sync_q[STAGES-1];
  assign rise = sync_q[STAGES-1] & ~last_q;
  assign fall = ~sync_q[STAGES-1] & last_q;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 slave feeding a NUM_REGS x DATA_W register file, with read-back on
// CIPO, range/length checking and commit/error strobes.
`timescale 1ns/1ps
module spi_regfile_peripheral
  import spi_regfile_pkg::*;
#(
  parameter int NUM_REGS    = 8,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       copi,
  input  logic                       ncs,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
  localparam int CNT_W     = cnt_width(FRAME_LEN);

  localparam logic [CNT_W-1:0] CNT_LAST_ADDR = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_DATA0     = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0] CNT_LAST_DATA = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_FULL      = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX       = CNT_W'(FRAME_LEN + 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ncs_lvl, ncs_rise, ncs_fall;
  logic [SYNC_STAGES-1:0] copi_sync_q;
  logic copi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .d(sclk), .lvl(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b1)) u_ncs_sync (
    .clk(clk), .rst(rst), .d(ncs), .lvl(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) copi_sync_q <= '0;
    else     copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
  end
  assign copi_s = copi_sync_q[SYNC_STAGES-1];

  state_e                           state_q, state_d;
  logic [CNT_W-1:0]                 cnt_q;
  logic                             rw_q;
  logic [ADDR_W-1:0]                addr_q;
  logic [DATA_W-1:0]                data_q;
  logic [DATA_W-1:0]                tx_q;
  logic                             cipo_oe_q;
  logic                             load_q;
  logic                             commit_q;
  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_q;
  logic                             wr_strobe_q;
  logic [ADDR_W-1:0]                wr_addr_q;
  logic                             frame_err_q;

  logic              bit_ev;
  logic              addr_ok;
  logic [DATA_W-1:0] rd_data;

  // Synchronised ncs is already high in the ncs-rise clk, so this also drops a coincident sclk edge.
  assign bit_ev  = sclk_rise & ~ncs_lvl & (state_q != IDLE);
  assign addr_ok = ({1'b0, addr_q} < (ADDR_W + 1)'(NUM_REGS));

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_q == ADDR_W'(i)) rd_data = regs_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ncs_rise) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      if (ncs_fall) state_d = CMD;
    end else if (bit_ev) begin
      case (state_q)
        CMD:     state_d = ADDR;
        ADDR:    if (cnt_q == CNT_LAST_ADDR) state_d = DATA;
        DATA:    if (cnt_q == CNT_LAST_DATA) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      tx_q        <= '0;
      cipo_oe_q   <= 1'b0;
      load_q      <= 1'b0;
      commit_q    <= 1'b0;
      regs_q      <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      load_q      <= 1'b0;
      commit_q    <= 1'b0;

      // Uses the previous frame's fields even if a new frame starts this clk.
      if (commit_q) begin
        if (cnt_q == CNT_FULL && addr_ok) begin
          if (rw_q == RW_WRITE) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (addr_q == ADDR_W'(i)) regs_q[i] <= data_q;
            end
            wr_strobe_q <= 1'b1;
            wr_addr_q   <= addr_q;
          end
        end else begin
          frame_err_q <= 1'b1;
        end
      end

      if (state_q == IDLE && ncs_fall) cnt_q <= '0;

      if (bit_ev) begin
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
        if (cnt_q == '0) begin
          rw_q <= copi_s;
        end else if (cnt_q <= CNT_LAST_ADDR) begin
          addr_q <= ADDR_W'({addr_q, copi_s});
        end else if (cnt_q < CNT_FULL) begin
          data_q <= DATA_W'({data_q, copi_s});
        end
        if (state_q == ADDR && cnt_q == CNT_LAST_ADDR && rw_q != RW_WRITE) load_q <= 1'b1;
      end

      // The falling edge right after the last address bit must not shift: the MSB
      // has to survive until the first data rising edge.
      if (load_q) begin
        tx_q      <= rd_data;
        cipo_oe_q <= 1'b1;
      end else if (sclk_fall && !sclk_lvl && cipo_oe_q && cnt_q > CNT_DATA0) begin
        tx_q <= tx_q << 1;
      end

      if (ncs_rise && state_q != IDLE) begin
        cipo_oe_q <= 1'b0;
        commit_q  <= (cnt_q != '0);
      end
    end
  end

  assign cipo      = cipo_oe_q & tx_q[DATA_W-1];
  assign cipo_oe   = cipo_oe_q;
  assign regs_out  = regs_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Directed bench for spi_regfile_peripheral: bit-banged SPI frames with hand-computed expectations.
`timescale 1ns/1ps
module tb_spi_regfile_peripheral;

  localparam int NUM_REGS = 8;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 7;
  localparam int SS       = 2;
  localparam int HP       = 6;

  logic clk = 1'b0;
  logic rst, sclk, copi, ncs;
  logic cipo, cipo_oe, wr_strobe, frame_err;
  logic [NUM_REGS*DATA_W-1:0] regs_out;
  logic [ADDR_W-1:0] wr_addr;

  int checks = 0;
  int errors = 0;
  int n_strobe = 0;
  int n_err = 0;

  spi_regfile_peripheral #(
    .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
    .cipo(cipo), .cipo_oe(cipo_oe), .regs_out(regs_out),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) n_strobe++;
    if (frame_err === 1'b1) n_err++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] frm(input logic rw, input logic [6:0] a, input logic [7:0] d);
    return {rw, a, d};
  endfunction

  // Drives one frame MSB-first; rx/oe hold cipo/cipo_oe as seen just before each sclk rise.
  task automatic spi_frame(input logic [31:0] bits, input int nbits, input int hp, input int gap,
                           output logic [31:0] rx, output logic [31:0] oe);
    rx = '0;
    oe = '0;
    ncs = 1'b0;
    wait_clk(hp);
    for (int k = 0; k < nbits; k++) begin
      copi = bits[nbits-1-k];
      wait_clk(hp);
      rx[nbits-1-k] = cipo;
      oe[nbits-1-k] = cipo_oe;
      sclk = 1'b1;
      wait_clk(hp);
      sclk = 1'b0;
    end
    wait_clk(hp);
    ncs  = 1'b1;
    copi = 1'b0;
    wait_clk(gap);
  endtask

  task automatic test_reset();
    rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    wait_clk(3);
    checks++; if (regs_out !== '0) begin errors++; $display("FAIL reset_regs: got %h expected 0", regs_out); end
    checks++; if ({cipo, cipo_oe, wr_strobe, frame_err} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {cipo, cipo_oe, wr_strobe, frame_err}); end
    checks++; if (wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr: got %h expected 0", wr_addr); end
    rst = 1'b0;
    wait_clk(5);
  endtask

  task automatic test_write_read();
    logic [31:0] rx, oe;
    int s0, e0;
    s0 = n_strobe; e0 = n_err;
    spi_frame(32'(frm(1'b1, 7'd2, 8'hA5)), 16, HP, 10, rx, oe);
    checks++; if (regs_out[23:16] !== 8'hA5) begin errors++; $display("FAIL wr_reg2: got %h expected a5", regs_out[23:16]); end
    checks++; if (regs_out !== 64'h0000_0000_00A5_0000) begin errors++; $display("FAIL wr_bus: got %h expected 0000000000a50000", regs_out); end
    checks++; if (n_strobe - s0 !== 1) begin errors++; $display("FAIL wr_strobe_count: got %0d expected 1", n_strobe - s0); end
    checks++; if (wr_addr !== 7'd2) begin errors++; $display("FAIL wr_addr: got %0d expected 2", wr_addr); end
    checks++; if (oe !== 32'h0) begin errors++; $display("FAIL wr_oe: got %h expected 0", oe); end
    spi_frame(32'(frm(1'b0, 7'd2, 8'h00)), 16, HP, 10, rx, oe);
    checks++; if (rx[7:0] !== 8'hA5) begin errors++; $display("FAIL rd_cipo: got %h expected a5", rx[7:0]); end
    checks++; if (oe[15:0] !== 16'h00FF) begin errors++; $display("FAIL rd_oe_window: got %h expected 00ff", oe[15:0]); end
    checks++; if (cipo_oe !== 1'b0) begin errors++; $display("FAIL rd_oe_after: got %b expected 0", cipo_oe); end
    checks++; if (n_strobe - s0 !== 1 || n_err - e0 !== 0) begin errors++; $display("FAIL rd_no_strobe: got strobes %0d errs %0d expected 1 0", n_strobe - s0, n_err - e0); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rx, oe;
    int s0, e0;
    s0 = n_strobe; e0 = n_err;
    spi_frame(32'(frm(1'b1, 7'd9, 8'hFF)), 16, HP, 10, rx, oe);
    checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL oor_wr_err: got %0d expected 1", n_err - e0); end
    checks++; if (n_strobe - s0 !== 0) begin errors++; $display("FAIL oor_wr_strobe: got %0d expected 0", n_strobe - s0); end
    checks++; if (regs_out !== 64'h0000_0000_00A5_0000) begin errors++; $display("FAIL oor_wr_bus: got %h expected 0000000000a50000", regs_out); end
    spi_frame(32'(frm(1'b0, 7'd9, 8'h00)), 16, HP, 10, rx, oe);
    checks++; if (rx[7:0] !== 8'h00) begin errors++; $display("FAIL oor_rd_cipo: got %h expected 00", rx[7:0]); end
    checks++; if (n_err - e0 !== 2) begin errors++; $display("FAIL oor_rd_err: got %0d expected 2", n_err - e0); end
  endtask

  task automatic test_length();
    logic [31:0] rx, oe;
    logic [31:0] f;
    int s0, e0;
    s0 = n_strobe; e0 = n_err;
    f = 32'(frm(1'b1, 7'd0, 8'h3C));
    spi_frame(f >> 1, 15, HP, 10, rx, oe);
    checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL short_err: got %0d expected 1", n_err - e0); end
    spi_frame(f << 1, 17, HP, 10, rx, oe);
    checks++; if (n_err - e0 !== 2) begin errors++; $display("FAIL long_err: got %0d expected 2", n_err - e0); end
    checks++; if (regs_out[7:0] !== 8'h00 || n_strobe - s0 !== 0) begin errors++; $display("FAIL len_reg0: got %h strobes %0d expected 00 0", regs_out[7:0], n_strobe - s0); end
    spi_frame(32'h0, 0, 8, 10, rx, oe);
    checks++; if (n_err - e0 !== 2) begin errors++; $display("FAIL empty_select: got %0d expected 2", n_err - e0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rx, oe;
    int s0, e0;
    s0 = n_strobe; e0 = n_err;
    for (int i = 0; i < NUM_REGS; i++) begin
      spi_frame(32'(frm(1'b1, 7'(i), 8'(17 * (i + 1)))), 16, 5, SS + 3, rx, oe);
    end
    wait_clk(10);
    checks++; if (regs_out !== 64'h8877665544332211) begin errors++; $display("FAIL b2b_bus: got %h expected 8877665544332211", regs_out); end
    checks++; if (n_strobe - s0 !== 8 || n_err - e0 !== 0) begin errors++; $display("FAIL b2b_counts: got strobes %0d errs %0d expected 8 0", n_strobe - s0, n_err - e0); end
    checks++; if (wr_addr !== 7'd7) begin errors++; $display("FAIL b2b_wr_addr: got %0d expected 7", wr_addr); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rx, oe;
    logic [15:0] f;
    int s0, e0;
    f = frm(1'b1, 7'd1, 8'h5A);
    s0 = n_strobe; e0 = n_err;
    ncs = 1'b0;
    wait_clk(HP);
    for (int k = 0; k < 10; k++) begin
      copi = f[15-k];
      wait_clk(HP);
      sclk = 1'b1;
      wait_clk(HP);
      sclk = 1'b0;
    end
    rst = 1'b1;
    wait_clk(1);
    checks++; if (regs_out !== '0 || wr_addr !== '0) begin errors++; $display("FAIL midrst_state: got %h addr %0d expected 0 0", regs_out, wr_addr); end
    checks++; if ({cipo, cipo_oe, wr_strobe, frame_err} !== 4'b0) begin errors++; $display("FAIL midrst_flags: got %b expected 0000", {cipo, cipo_oe, wr_strobe, frame_err}); end
    rst = 1'b0; ncs = 1'b1; copi = 1'b0;
    wait_clk(10);
    checks++; if (n_strobe - s0 !== 0 || n_err - e0 !== 0) begin errors++; $display("FAIL midrst_silent: got strobes %0d errs %0d expected 0 0", n_strobe - s0, n_err - e0); end
    spi_frame(32'(f), 16, HP, 10, rx, oe);
    checks++; if (regs_out !== 64'h0000_0000_0000_5A00) begin errors++; $display("FAIL midrst_rewrite: got %h expected 0000000000005a00", regs_out); end
    checks++; if (n_strobe - s0 !== 1 || wr_addr !== 7'd1) begin errors++; $display("FAIL midrst_strobe: got %0d addr %0d expected 1 1", n_strobe - s0, wr_addr); end
  endtask

  task automatic test_min_speed_read();
    logic [31:0] rx, oe;
    spi_frame(32'(frm(1'b1, 7'd3, 8'h0F)), 16, SS + 2, 10, rx, oe);
    checks++; if (regs_out[31:24] !== 8'h0F) begin errors++; $display("FAIL fast_wr_reg3: got %h expected 0f", regs_out[31:24]); end
    spi_frame(32'(frm(1'b0, 7'd3, 8'h00)), 16, SS + 2, 10, rx, oe);
    checks++; if (rx[7:0] !== 8'h0F) begin errors++; $display("FAIL fast_rd_cipo: got %h expected 0f", rx[7:0]); end
    checks++; if (oe[15:0] !== 16'h00FF) begin errors++; $display("FAIL fast_rd_oe: got %h expected 00ff", oe[15:0]); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_out_of_range();
    test_length();
    test_back_to_back();
    test_reset_mid_frame();
    test_min_speed_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
